// File: rtl/prescaled_counter.sv
`default_nettype none
// ============================================================================
// Module   : prescaled_counter
// Purpose  : Runtime-programmable prescaler driving a bounded up/down counter
//            with wrap, one-shot and saturate end-of-range behaviour, plus
//            one-cycle tick/wrap pulses and a latched done flag.
// Revision : 1.0 - initial release
// ============================================================================
module prescaled_counter #(
  parameter int CNT_W = 32,
  parameter int PRE_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [PRE_W-1:0] div,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] out,
  output logic             tick,
  output logic             wrap,
  output logic             done
);

  // End-of-range behaviours; the unused encoding falls back to wrap.
  localparam logic [1:0] c_mode_wrap    = 2'b00;
  localparam logic [1:0] c_mode_oneshot = 2'b01;
  localparam logic [1:0] c_mode_sat     = 2'b10;

  localparam logic [PRE_W-1:0] c_pre_one = {{(PRE_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [PRE_W-1:0] r_p;          // prescaler phase
  logic [PRE_W-1:0] w_div_m1;     // last phase value before rollover
  logic             w_run;        // counting allowed this cycle
  logic             w_roll;       // prescaler reaches its rollover this cycle
  logic             w_term;       // counter sits at its terminal value
  logic [CNT_W-1:0] w_out_next;
  logic             w_wrap_next;
  logic             w_done_next;

  // div of 0 behaves like 1, so the rollover threshold is div-1 clamped at 0.
  assign w_div_m1 = (div == '0) ? '0 : (div - c_pre_one);

  // A latched done freezes everything until clr/load/rst.
  assign w_run  = en && !done;

  // >= rather than == so that lowering div below the current phase still
  // rolls over on the next enabled cycle instead of running through 2^PRE_W.
  assign w_roll = (r_p >= w_div_m1);

  // Up uses >= so a lowered limit or an out-of-range load is still terminal.
  assign w_term = dir ? (out == '0) : (out >= limit);

  // Counter result of a tick: step, or apply the end-of-range behaviour.
  always_comb begin
    w_out_next  = out;
    w_wrap_next = 1'b0;
    w_done_next = 1'b0;
    if (!w_term) begin
      w_out_next = dir ? (out - c_cnt_one) : (out + c_cnt_one);
    end else begin
      case (mode)
        c_mode_oneshot: begin
          w_wrap_next = 1'b1;
          w_done_next = 1'b1;
        end
        c_mode_sat: begin
          w_out_next = out;
        end
        default: begin // c_mode_wrap and the spare encoding
          w_out_next  = dir ? limit : '0;
          w_wrap_next = 1'b1;
        end
      endcase
    end
  end

  // Prescaler phase: cleared by clr/load, held while frozen, else advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p <= '0;
    end else if (clr || load) begin
      r_p <= '0;
    end else if (w_run) begin
      r_p <= w_roll ? '0 : (r_p + c_pre_one);
    end
  end

  // Count, pulses and done flag; pulses are only ever set for one tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
      done <= 1'b0;
    end else if (clr) begin
      out  <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
      done <= 1'b0;
    end else if (load) begin
      out  <= load_val;
      tick <= 1'b0;
      wrap <= 1'b0;
      done <= 1'b0;
    end else if (w_run && w_roll) begin
      out  <= w_out_next;
      tick <= 1'b1;
      wrap <= w_wrap_next;
      done <= w_done_next;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prescaled_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prescaled_counter
// Purpose  : Self-checking bench for prescaled_counter: a table of per-cycle
//            input/expected-output records plus hand-written reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prescaled_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic        load;
  logic [31:0] load_val;
  logic        dir;
  logic [1:0]  mode;
  logic [31:0] div;
  logic [31:0] limit;
  logic [31:0] out;
  logic        tick;
  logic        wrap;
  logic        done;

  int n_total;
  int n_pass;

  typedef struct {
    string       name;
    logic        en;
    logic        clr;
    logic        load;
    logic [31:0] load_val;
    logic        dir;
    logic [1:0]  mode;
    logic [31:0] div;
    logic [31:0] limit;
    logic [31:0] e_out;
    logic        e_tick;
    logic        e_wrap;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  // Running configuration used while filling the table.
  logic        c_en;
  logic        c_dir;
  logic [1:0]  c_mode;
  logic [31:0] c_div;
  logic [31:0] c_limit;

  prescaled_counter #(.CNT_W(32), .PRE_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .mode     (mode),
    .div      (div),
    .limit    (limit),
    .out      (out),
    .tick     (tick),
    .wrap     (wrap),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(string nm, logic cl, logic ld, logic [31:0] lv,
                              logic [31:0] eo, logic et, logic ew, logic ed);
    vec_t v;
    v.name = nm; v.en = c_en; v.clr = cl; v.load = ld; v.load_val = lv;
    v.dir = c_dir; v.mode = c_mode; v.div = c_div; v.limit = c_limit;
    v.e_out = eo; v.e_tick = et; v.e_wrap = ew; v.e_done = ed;
    vecs.push_back(v);
  endfunction

  task automatic check(string nm, logic [31:0] eo, logic et, logic ew, logic ed);
    n_total++;
    if (out === eo && tick === et && wrap === ew && done === ed) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got out=%0d tick=%b wrap=%b done=%b, want out=%0d tick=%b wrap=%b done=%b",
               nm, out, tick, wrap, done, eo, et, ew, ed);
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    // ---------------- table fill ----------------
    // Prescale by 3, wrap up at limit 4.
    c_en = 1'b1; c_dir = 1'b0; c_mode = 2'b00; c_div = 32'd3; c_limit = 32'd4;
    add("upwrap_clr", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 15; k++)
      add($sformatf("upwrap_c%0d", k), 1'b0, 1'b0, 32'd0,
          32'((k / 3) % 5), (k % 3) == 0, k == 15, 1'b0);

    // div=0 acts as 1, down wrap at limit 2: 0 -> 2 -> 1 -> 0 -> 2.
    c_dir = 1'b1; c_div = 32'd0; c_limit = 32'd2;
    add("dnwrap_clr", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    add("dnwrap_c1", 1'b0, 1'b0, 32'd0, 32'd2, 1'b1, 1'b1, 1'b0);
    add("dnwrap_c2", 1'b0, 1'b0, 32'd0, 32'd1, 1'b1, 1'b0, 1'b0);
    add("dnwrap_c3", 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    add("dnwrap_c4", 1'b0, 1'b0, 32'd0, 32'd2, 1'b1, 1'b1, 1'b0);

    // limit=0 in wrap mode: every tick is terminal.
    c_dir = 1'b0; c_div = 32'd1; c_limit = 32'd0;
    add("lim0_clr", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++)
      add($sformatf("lim0_c%0d", k), 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);

    // One-shot countdown from 3 with div=2.
    c_dir = 1'b1; c_mode = 2'b01; c_div = 32'd2; c_limit = 32'd7;
    add("oneshot_load", 1'b0, 1'b1, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++)
      add($sformatf("oneshot_c%0d", k), 1'b0, 1'b0, 32'd0,
          32'(3 - k / 2), (k % 2) == 0, 1'b0, 1'b0);
    add("oneshot_done", 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 20; k++)
      add($sformatf("oneshot_frozen%0d", k), 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    c_dir = 1'b0;
    add("oneshot_clr", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    add("oneshot_res1", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    add("oneshot_res2", 1'b0, 1'b0, 32'd0, 32'd1, 1'b1, 1'b0, 1'b0);

    // Saturate at 5, then lower limit, then reverse direction.
    c_mode = 2'b10; c_div = 32'd1; c_limit = 32'd5;
    add("sat_clr", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++)
      add($sformatf("sat_up%0d", k), 1'b0, 1'b0, 32'd0, 32'(k), 1'b1, 1'b0, 1'b0);
    add("sat_hold1", 1'b0, 1'b0, 32'd0, 32'd5, 1'b1, 1'b0, 1'b0);
    add("sat_hold2", 1'b0, 1'b0, 32'd0, 32'd5, 1'b1, 1'b0, 1'b0);
    c_limit = 32'd3;
    add("sat_lowlim", 1'b0, 1'b0, 32'd0, 32'd5, 1'b1, 1'b0, 1'b0);
    c_dir = 1'b1;
    add("sat_dn1", 1'b0, 1'b0, 32'd0, 32'd4, 1'b1, 1'b0, 1'b0);
    add("sat_dn2", 1'b0, 1'b0, 32'd0, 32'd3, 1'b1, 1'b0, 1'b0);
    add("sat_dn3", 1'b0, 1'b0, 32'd0, 32'd2, 1'b1, 1'b0, 1'b0);

    // Enable freeze mid-prescale keeps the phase (div=4).
    c_dir = 1'b0; c_mode = 2'b00; c_div = 32'd4; c_limit = 32'd9;
    add("en_clr", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    add("en_c1", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    add("en_c2", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    c_en = 1'b0;
    for (int k = 1; k <= 7; k++)
      add($sformatf("en_off%0d", k), 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    c_en = 1'b1;
    add("en_c3", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    add("en_c4", 1'b0, 1'b0, 32'd0, 32'd1, 1'b1, 1'b0, 1'b0);
    for (int k = 5; k <= 7; k++)
      add($sformatf("en_c%0d", k), 1'b0, 1'b0, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0);
    add("en_c8", 1'b0, 1'b0, 32'd0, 32'd2, 1'b1, 1'b0, 1'b0);

    // Priority: clr beats load; load on a would-be tick suppresses it.
    add("clr_and_load", 1'b1, 1'b1, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++)
      add($sformatf("pre_ldtick%0d", k), 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    add("load_on_tick", 1'b0, 1'b1, 32'd6, 32'd6, 1'b0, 1'b0, 1'b0);

    // Load above limit counts as terminal on the next tick.
    add("load_oor", 1'b0, 1'b1, 32'd12, 32'd12, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++)
      add($sformatf("oor_c%0d", k), 1'b0, 1'b0, 32'd0, 32'd12, 1'b0, 1'b0, 1'b0);
    add("oor_wrap", 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);

    // ---------------- reset state ----------------
    rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
    dir = 1'b0; mode = 2'b00; div = 32'd1; limit = 32'd9;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // ---------------- table application ----------------
    foreach (vecs[i]) begin
      en = vecs[i].en; clr = vecs[i].clr; load = vecs[i].load;
      load_val = vecs[i].load_val; dir = vecs[i].dir; mode = vecs[i].mode;
      div = vecs[i].div; limit = vecs[i].limit;
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].e_out, vecs[i].e_tick, vecs[i].e_wrap, vecs[i].e_done);
    end

    // ---------------- async reset mid-count ----------------
    en = 1'b1; clr = 1'b1; load = 1'b0; dir = 1'b0; mode = 2'b00;
    div = 32'd1; limit = 32'd9;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_count5", 32'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_reset_clears", 32'd0, 1'b0, 1'b0, 1'b0);
    div = 32'd3;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // First tick after release lands on the div_eff-th edge.
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset_c%0d", k), (k == 3) ? 32'd1 : 32'd0, k == 3, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prescaled_counter.md
# prescaled_counter

Programmable prescaled tick counter, the next generation of the game's fixed divide-and-wrap counter. A runtime-programmable prescaler divides `clk` into ticks, and each tick steps a CNT_W-bit counter up or down within 0..`limit`. Three end-of-range modes are supported: wrap, one-shot and saturate. The block adds enable, synchronous clear, parallel load, one-cycle tick/wrap pulses and a latched done flag, for animation timers, spawn timers and countdowns.

## Interface
- CNT_W, 32: counter width.
- PRE_W, 32: prescaler width.

- clk  in  1  system clock; all state is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  enables the prescaler and counter; low freezes all state, no pulses.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load of `load_val`.
- load_val  in  CNT_W  value for `load`.
- dir  in  1  0 = count up, 1 = count down.
- mode  in  2  00 wrap, 01 one-shot, 10 saturate, 11 treated as wrap.
- div  in  PRE_W  ticks every `div` enabled cycles; 0 is treated as 1.
- limit  in  CNT_W  inclusive upper bound; the count range is 0..limit.
- out  out  CNT_W  current count, registered.
- tick  out  1  registered one-cycle pulse per prescaler rollover.
- wrap  out  1  registered one-cycle pulse on a terminal event.
- done  out  1  one-shot completion, latched.

## Operation
- The internal prescaler `p` is PRE_W bits. `div_eff = (div==0) ? 1 : div`.
- Priority per edge: rst > clr > load > counting.
- rst (async): `out`=0, `p`=0, `tick`=0, `wrap`=0, `done`=0.
- clr: `out`=0, `p`=0, `done`=0; no pulses that cycle.
- load: `out`=`load_val` (not clamped to `limit`), `p`=0, `done`=0; no pulses.
- Counting applies only when en=1 and done=0:
  - If `p >= div_eff-1`, then `p`=0 and a tick occurs. Using >= keeps the prescaler safe when `div` is lowered mid-count.
  - Otherwise `p` = `p`+1 and no tick occurs.
- Terminal condition:
  - Up: `out >= limit`; covers `limit` lowered below the count, or an out-of-range load.
  - Down: `out == 0`.
- On a tick, not at terminal: `out` steps ±1; `wrap` stays 0.
- On a tick, at terminal:
  - Wrap mode, up: `out`=0, `wrap` pulses.
  - Wrap mode, down: `out`=`limit`, `wrap` pulses.
  - One-shot: `out` holds, `done`=1, `wrap` pulses once.
  - Saturate: `out` holds, no `wrap`, no `done`. Counting resumes when `dir` flips or `limit` rises.
- Once `done`=1, the prescaler and counter freeze and `tick` stops. Only clr, load or rst releases it.
- `dir`, `mode`, `div` and `limit` are sampled live each edge; changes take effect on the next tick evaluation.
- All arithmetic is unsigned modulo the field width; the ±1 step never crosses a terminal, so no overflow is reachable.
- `limit`=0, wrap mode: every tick is a terminal event, so `out` stays 0 and `wrap` pulses on every tick.

## Timing
- `out`, `tick`, `wrap` and `done` all update on the same edge as the triggering event. `wrap` and the wrapped `out` value become visible together.
- Tick period is `div_eff` enabled cycles. With en held high, the first `tick` follows the `div_eff`-th edge after reset release, clr or load.
- `div`=1 ticks on every enabled cycle.
- en=0 holds `p` exactly, so the tick phase resumes without loss.
- `tick` and `wrap` are never high for more than one consecutive cycle unless `div_eff`=1.
- rst asserted mid-count clears every output immediately (asynchronously); counting restarts from `p`=0 after release.
- clr or load asserted in the same cycle as a would-be tick: the tick is suppressed and `tick`=`wrap`=0.

## Test plan
- Reset/defaults: assert rst mid-count with `out`=5 → `out`, `tick`, `wrap`, `done` read 0 before the next clk edge.
- Prescale and wrap up: div=3, limit=4, mode=00, dir=0, en=1 → `out` steps 0,1,2,3,4,0 every 3 cycles; `tick` pulses every 3rd cycle; `wrap` pulses together with `out` 4→0.
- Down wrap and div=0: div=0, limit=2, dir=1 → `out` sequence 0→2→1→0→2, one step per cycle; `wrap` pulses on each 0→2.
- One-shot: load `load_val`=3, dir=1, mode=01, div=2 → `out` 3,2,1,0. On the next tick, `done`=1 with one `wrap` pulse; then `out` stays 0 and `tick` stays low for 20 cycles. clr → `done`=0 and counting resumes.
- Saturate and limit change: mode=10, limit=5, count up → `out` holds at 5 with no `wrap`. Change limit to 3 → next tick is terminal and holds 5. Set dir=1 → `out` goes 4,3,…
- Priority/enable: en=0 for 7 cycles mid-prescale → `p` and `out` unchanged. clr and load asserted together → `out`=0. load asserted on a tick cycle → `out`=`load_val`, `tick`=0.
